// File: rtl/entropy_sampler.sv
// -----------------------------------------------------------------------------
// entropy_sampler
//
// Samples a raw asynchronous entropy bit at a programmable interval. Each
// sampled bit can optionally pass through a von Neumann debiaser. The
// accepted bits are packed into WIDTH-bit words, and each word is offered
// on a valid/ready output. Sampling never stalls. A word that completes
// while the previous word is still pending is dropped, and the sticky
// overrun flag ovf records the loss.
//
// Parameters
//   WIDTH      output word width in bits (2..64)
//   DIV_W      width of the sample-interval divider input
//
// Ports
//   d_clk      clock; all state updates on its rising edge
//   d_rst      synchronous active-high reset
//   d_input    raw asynchronous entropy bit
//   en         sampling enable
//   vn_en      1 = von Neumann debias mode, 0 = raw bits
//   div        sample interval; a tick occurs every div+1 enabled cycles
//   out_ready  consumer accepts out_data this cycle
//   out_data   assembled random word, registered; first bit lands in MSB
//   out_valid  out_data holds an unconsumed word
//   ovf        sticky overrun flag; at least one word was dropped
// -----------------------------------------------------------------------------
module entropy_sampler #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 8
) (
    input  logic             d_clk,
    input  logic             d_rst,
    input  logic             d_input,
    input  logic             en,
    input  logic             vn_en,
    input  logic [DIV_W-1:0] div,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             ovf
);

    localparam int BCNT_W = $clog2(WIDTH + 1);

    logic              s1;
    logic              s2;
    logic [DIV_W-1:0]  cnt;
    logic              pair_pend;
    logic              pair_bit;
    logic              vn_last;
    // Only the low WIDTH-1 bits of the shift register ever reach a word.
    // The top bit would be shifted out unused, so it is not stored.
    logic [WIDTH-2:0]  sr;
    logic [BCNT_W-1:0] bcnt;

    logic              tick;
    logic              pend_live;
    logic              accept;
    logic              acc_bit;
    logic              complete;
    logic              consume;
    logic [WIDTH-1:0]  word;

    // A pending first-of-pair counts only if sampling stays enabled and the
    // mode did not change on this edge. In any other case, the current
    // tick starts a fresh pair.
    always_comb begin
        tick      = en && (cnt >= div);
        pend_live = pair_pend && en && (vn_en == vn_last);
        accept    = 1'b0;
        acc_bit   = s2;
        if (tick) begin
            if (!vn_en) begin
                accept = 1'b1;
            end else if (pend_live) begin
                accept  = (pair_bit != s2);
                acc_bit = pair_bit;
            end
        end
    end

    assign complete = accept && (bcnt == BCNT_W'(WIDTH - 1));
    assign word     = {sr, acc_bit};
    assign consume  = out_valid && out_ready;

    // Two-flop synchronizer for the asynchronous entropy source.
    always_ff @(posedge d_clk) begin
        if (d_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d_input;
            s2 <= s1;
        end
    end

    // Sample-interval divider. It only runs while enabled. Changing div
    // takes effect on the next compare and does not restart the count.
    always_ff @(posedge d_clk) begin
        if (d_rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Von Neumann pairing state. vn_last is used to detect a mode change.
    always_ff @(posedge d_clk) begin
        if (d_rst) begin
            pair_pend <= 1'b0;
            pair_bit  <= 1'b0;
            vn_last   <= 1'b0;
        end else begin
            vn_last <= vn_en;
            if (tick && vn_en) begin
                if (pend_live) begin
                    pair_pend <= 1'b0;
                end else begin
                    pair_pend <= 1'b1;
                    pair_bit  <= s2;
                end
            end else if (!en || (vn_en != vn_last)) begin
                pair_pend <= 1'b0;
            end
        end
    end

    // Word assembly. The shift register and bit counter are naturally
    // frozen while en=0, because no bit can be accepted then.
    always_ff @(posedge d_clk) begin
        if (d_rst) begin
            sr   <= '0;
            bcnt <= '0;
        end else if (accept) begin
            sr   <= word[WIDTH-2:0];
            bcnt <= complete ? '0 : bcnt + BCNT_W'(1);
        end
    end

    // Output handshake. A completed word replaces the current one only if
    // the slot is empty or is being consumed on the same edge. Otherwise
    // the new word is dropped and the overrun is recorded.
    always_ff @(posedge d_clk) begin
        if (d_rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (complete) begin
            if (!out_valid || out_ready) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else begin
                ovf <= 1'b1;
            end
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_entropy_sampler.sv
// -----------------------------------------------------------------------------
// tb_entropy_sampler
//
// Directed bench for entropy_sampler with WIDTH=8 and DIV_W=8. A
// queue-based reference model predicts out_data, out_valid and ovf. The
// model is updated at every rising edge and compared 1 ns later. Literal
// hand-computed expectations at scenario boundaries pin the model itself.
// -----------------------------------------------------------------------------
module tb_entropy_sampler;

    localparam int WIDTH = 8;
    localparam int DIV_W = 8;

    logic             d_clk     = 1'b0;
    logic             d_rst     = 1'b1;
    logic             d_input   = 1'b0;
    logic             en        = 1'b0;
    logic             vn_en     = 1'b0;
    logic [DIV_W-1:0] div       = '0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    int               din_hist[$];
    int               m_since;
    int               m_first;
    logic             m_prev_vn;
    int               m_bits[$];
    logic             m_valid;
    logic             m_ovf;
    logic [WIDTH-1:0] m_data;

    entropy_sampler #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .d_clk     (d_clk),
        .d_rst     (d_rst),
        .d_input   (d_input),
        .en        (en),
        .vn_en     (vn_en),
        .div       (div),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    initial begin
        forever #5 d_clk = ~d_clk;
    end

    // Advance the reference model by one rising edge, using the inputs
    // as they are presented at that edge.
    task automatic modelStep();
        int   samp;
        int   b;
        int   w;
        logic tick;
        logic got;
        logic done;
        if (d_rst) begin
            din_hist  = {0, 0};
            m_since   = 0;
            m_first   = -1;
            m_prev_vn = 1'b0;
            m_bits.delete();
            m_valid   = 1'b0;
            m_ovf     = 1'b0;
            m_data    = '0;
        end else begin
            // The sampled bit is d_input as it was two edges ago.
            samp = din_hist.pop_front();
            din_hist.push_back(int'(d_input));
            tick = 1'b0;
            if (!en) begin
                m_since = 0;
                m_first = -1;
            end else if (m_since >= int'(div)) begin
                tick    = 1'b1;
                m_since = 0;
            end else begin
                m_since++;
            end
            if (vn_en != m_prev_vn) m_first = -1;
            m_prev_vn = vn_en;
            got = 1'b0;
            b   = 0;
            if (tick) begin
                if (!vn_en) begin
                    got = 1'b1;
                    b   = samp;
                end else if (m_first < 0) begin
                    m_first = samp;
                end else begin
                    if (m_first != samp) begin
                        got = 1'b1;
                        b   = m_first;
                    end
                    m_first = -1;
                end
            end
            done = 1'b0;
            w    = 0;
            if (got) begin
                m_bits.push_back(b);
                if (m_bits.size() == WIDTH) begin
                    done = 1'b1;
                    foreach (m_bits[i]) w = (w << 1) | m_bits[i];
                    m_bits.delete();
                end
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    m_data  = WIDTH'(w);
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge d_clk);
            modelStep();
            #1;
            tests_run++;
            if (out_valid !== m_valid || ovf !== m_ovf || out_data !== m_data) begin
                tests_failed++;
                $display("[TB] FAIL cycle_model @%0t: got valid=%0b data=0x%02h ovf=%0b, expected valid=%0b data=0x%02h ovf=%0b",
                         $time, out_valid, out_data, ovf, m_valid, m_data, m_ovf);
            end
        end
    end

    // Drive one input set at a falling edge and hold it through n rising
    // edges. Return 1 ns after the last of those edges.
    task automatic applyStimulus(input logic din, input logic e, input logic v,
                                 input logic [DIV_W-1:0] dv, input logic rdy,
                                 input int n);
        @(negedge d_clk);
        d_rst     = 1'b0;
        d_input   = din;
        en        = e;
        vn_en     = v;
        div       = dv;
        out_ready = rdy;
        repeat (n) @(posedge d_clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge d_clk);
        d_rst     = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        @(posedge d_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_valid,
                               input logic [WIDTH-1:0] exp_data, input logic exp_ovf);
        tests_run++;
        if (out_valid !== exp_valid || out_data !== exp_data || ovf !== exp_ovf) begin
            tests_failed++;
            $display("[TB] FAIL %s: got valid=%0b data=0x%02h ovf=%0b, expected valid=%0b data=0x%02h ovf=%0b",
                     name, out_valid, out_data, ovf, exp_valid, exp_data, exp_ovf);
        end
    endtask

    // Feed nbits sample values MSB-first at div=0. The first two cycles
    // prime the synchronizer with en=0. Ticks then consume the bits in
    // order. out_ready is raised only on cycle rdy_at.
    task automatic feedBits(input logic [15:0] bits, input int nbits,
                            input logic v, input int rdy_at);
        for (int i = 0; i < nbits + 2; i++) begin
            applyStimulus((i < nbits) ? bits[nbits-1-i] : 1'b0,
                          (i >= 2), v, '0, (i == rdy_at), 1);
        end
    endtask

    initial begin
        int vn_pat[8];
        int clr_pat[4];
        vn_pat  = '{0, 1, 1, 0, 0, 0, 1, 1};
        clr_pat = '{1, 0, 0, 1};

        repeat (3) @(posedge d_clk);
        #1;
        checkOutput("reset_state", 1'b0, 8'h00, 1'b0);

        // Raw mode, div=0, constant ones.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 7);
        checkOutput("raw_after_7", 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1);
        checkOutput("raw_ff", 1'b1, 8'hFF, 1'b0);

        // Consume the word, then sample zeros every 4th cycle with div=3.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1);
        checkOutput("consume_ff", 1'b0, 8'hFF, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 31);
        checkOutput("div3_after_31", 1'b0, 8'hFF, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1);
        checkOutput("div3_word", 1'b1, 8'h00, 1'b0);

        // Von Neumann mode: pairs 01,10,00,11 repeated four times.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1);
        for (int i = 0; i < 34; i++) begin
            applyStimulus((i < 32) ? vn_pat[i % 8][0] : 1'b0, (i >= 2), 1'b1, 8'd0, 1'b0, 1);
        end
        checkOutput("vn_55", 1'b1, 8'h55, 1'b0);

        // Two words with no consumer: the second word is dropped and ovf is set.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1);
        feedBits(16'hA53C, 16, 1'b0, -1);
        checkOutput("overrun", 1'b1, 8'hA5, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1);
        checkOutput("ovf_sticky_pulse", 1'b0, 8'hA5, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2);
        checkOutput("ovf_sticky_idle", 1'b0, 8'hA5, 1'b1);

        // Reset clears ovf. Consuming on word 2's completion edge loads it back to back.
        doReset();
        checkOutput("reset_clears_ovf", 1'b0, 8'h00, 1'b0);
        feedBits(16'hA53C, 16, 1'b0, 17);
        checkOutput("back_to_back", 1'b1, 8'h3C, 1'b0);

        // Reset mid-word while a word is held. The next word needs 8 fresh bits.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 5);
        checkOutput("held_during_partial", 1'b1, 8'h3C, 1'b0);
        doReset();
        checkOutput("reset_mid_word", 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 7);
        checkOutput("fresh_after_7", 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1);
        checkOutput("fresh_word", 1'b1, 8'hFF, 1'b0);

        // VN mode with en dropped between the halves of each would-be pair.
        // Each drop clears the pending sample, so every unit yields a 0 bit.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1);
        checkOutput("consume_fresh", 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 34; i++) begin
            applyStimulus((i < 32) ? clr_pat[i % 4][0] : 1'b0,
                          (i >= 2) && (((i - 2) % 4) != 1), 1'b1, 8'd0, 1'b0, 1);
        end
        checkOutput("vn_en_clear", 1'b1, 8'h00, 1'b0);

        @(negedge d_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
